// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
//   Shared constants for the operand fetch stage and its register file:
//   default widths, field widths, the op-code bit that selects the
//   immediate, NZCV bit positions and the condition-code encodings.
//   Also provides cond_pass(), which evaluates a condition against NZCV.
// -----------------------------------------------------------------------------
package cpu_pkg;

    // Default datapath geometry; modules expose these as overridable parameters.
    localparam int DEF_DATA_W   = 32;
    localparam int DEF_NUM_REGS = 16;
    localparam int DEF_IMM_W    = 16;

    // Fixed instruction field widths.
    localparam int OP_W    = 4;
    localparam int COND_W  = 4;
    localparam int FLAGS_W = 4;

    // op_code[OP_IMM_BIT] = 1 selects the zero-extended immediate as operand B.
    localparam int OP_IMM_BIT = 3;

    // Bit positions inside the {N,Z,C,V} flag vector.
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [COND_W-1:0] {
        COND_AL = 4'd0,
        COND_EQ = 4'd1,
        COND_NE = 4'd2,
        COND_CS = 4'd3,
        COND_CC = 4'd4,
        COND_MI = 4'd5,
        COND_PL = 4'd6,
        COND_VS = 4'd7,
        COND_VC = 4'd8,
        COND_HI = 4'd9,
        COND_LS = 4'd10,
        COND_GE = 4'd11,
        COND_LT = 4'd12,
        COND_GT = 4'd13,
        COND_LE = 4'd14,
        COND_NV = 4'd15
    } cond_e;

    // Returns 1 when the instruction's condition holds for the given flags.
    function automatic logic cond_pass(input logic [COND_W-1:0]  cond,
                                       input logic [FLAGS_W-1:0] nzcv);
        logic n, z, c, v;
        logic pass;
        n = nzcv[FLAG_N];
        z = nzcv[FLAG_Z];
        c = nzcv[FLAG_C];
        v = nzcv[FLAG_V];
        case (cond_e'(cond))
            COND_AL: pass = 1'b1;
            COND_EQ: pass = z;
            COND_NE: pass = !z;
            COND_CS: pass = c;
            COND_CC: pass = !c;
            COND_MI: pass = n;
            COND_PL: pass = !n;
            COND_VS: pass = v;
            COND_VC: pass = !v;
            COND_HI: pass = c && !z;
            COND_LS: pass = !c || z;
            COND_GE: pass = (n == v);
            COND_LT: pass = (n != v);
            COND_GT: pass = !z && (n == v);
            COND_LE: pass = z || (n != v);
            default: pass = 1'b0;   // COND_NV: never executes
        endcase
        return pass;
    endfunction

endpackage

// File: rtl/regfile.sv
// -----------------------------------------------------------------------------
// regfile
//   NUM_REGS x DATA_W architectural register file.
//   Two asynchronous read ports and one synchronous write port. A write in
//   the current cycle is bypassed onto both read ports (write-first), so a
//   consumer reading the same address sees the new value immediately.
//
// Ports
//   clk, reset            clock, asynchronous active-high reset (clears all)
//   rd_addr_a/rd_data_a   read port A
//   rd_addr_b/rd_data_b   read port B
//   wr_en/wr_addr/wr_data write port
// -----------------------------------------------------------------------------
module regfile #(
    parameter  int DATA_W   = cpu_pkg::DEF_DATA_W,
    parameter  int NUM_REGS = cpu_pkg::DEF_NUM_REGS,
    localparam int AW       = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [AW-1:0]     rd_addr_a,
    output logic [DATA_W-1:0] rd_data_a,
    input  logic [AW-1:0]     rd_addr_b,
    output logic [DATA_W-1:0] rd_data_b,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data
);

    logic [DATA_W-1:0] mem [NUM_REGS];

    // NOTE: the array is reset explicitly because a reset must leave every
    // register reading zero; this keeps it in flops rather than a RAM macro.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            // NOTE: sequential state uses non-blocking assignment so every
            // flop samples pre-edge values regardless of statement order.
            mem[wr_addr] <= wr_data;
        end
    end

    // Write-first bypass: same-cycle writeback wins over the stored value.
    always_comb begin
        rd_data_a = mem[rd_addr_a];
        rd_data_b = mem[rd_addr_b];
        if (wr_en && (wr_addr == rd_addr_a)) rd_data_a = wr_data;
        if (wr_en && (wr_addr == rd_addr_b)) rd_data_b = wr_data;
    end

endmodule

// File: rtl/operand_fetch_stage.sv
// -----------------------------------------------------------------------------
// operand_fetch_stage
//   Sits after the fetch/decode register. Reads source operands from the
//   architectural register file, evaluates the condition field against
//   NZCV, tracks in-flight destinations and flag writers in a busy
//   scoreboard, stalls upstream on RAW/WAW/flag hazards, and hands a
//   registered operand bundle to execute over a valid/ready handshake.
//
// Ports
//   clk, reset               clock, asynchronous active-high reset
//   in_valid / in_ready      upstream handshake (decoded instruction)
//   op_code_in ...
//   immediat_value_in        decoded instruction fields
//   wb_en/wb_addr/wb_data    register writeback from execute/writeback
//   wb_flags_en/wb_flags     NZCV writeback
//   out_valid / out_ready    downstream handshake (operand bundle)
//   op_code_out, s_bit_out,
//   destination_out,
//   operand_a_out,
//   operand_b_out            registered operand bundle
//   flags_out                current NZCV including same-cycle writeback
// -----------------------------------------------------------------------------
module operand_fetch_stage
    import cpu_pkg::*;
#(
    parameter  int DATA_W   = DEF_DATA_W,
    parameter  int NUM_REGS = DEF_NUM_REGS,
    parameter  int IMM_W    = DEF_IMM_W,
    localparam int AW       = $clog2(NUM_REGS)
) (
    input  logic               clk,
    input  logic               reset,

    input  logic               in_valid,
    output logic               in_ready,
    input  logic [OP_W-1:0]    op_code_in,
    input  logic [COND_W-1:0]  condition_in,
    input  logic               s_bit_in,
    input  logic [AW-1:0]      destination_in,
    input  logic [AW-1:0]      src1_in,
    input  logic [AW-1:0]      src2_in,
    input  logic [IMM_W-1:0]   immediat_value_in,

    input  logic               wb_en,
    input  logic [AW-1:0]      wb_addr,
    input  logic [DATA_W-1:0]  wb_data,
    input  logic               wb_flags_en,
    input  logic [FLAGS_W-1:0] wb_flags,

    output logic               out_valid,
    input  logic               out_ready,
    output logic [OP_W-1:0]    op_code_out,
    output logic               s_bit_out,
    output logic [AW-1:0]      destination_out,
    output logic [DATA_W-1:0]  operand_a_out,
    output logic [DATA_W-1:0]  operand_b_out,
    output logic [FLAGS_W-1:0] flags_out
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [NUM_REGS-1:0] busy_q;        // destination written by an in-flight op
    logic                flag_busy_q;   // an in-flight op will write NZCV
    logic [FLAGS_W-1:0]  flags_q;

    // ------------------------------------------------------------------
    // Register file with same-cycle writeback bypass
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] rf_rd_a;
    logic [DATA_W-1:0] rf_rd_b;

    regfile #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS)
    ) u_regfile (
        .clk       (clk),
        .reset     (reset),
        .rd_addr_a (src1_in),
        .rd_data_a (rf_rd_a),
        .rd_addr_b (src2_in),
        .rd_data_b (rf_rd_b),
        .wr_en     (wb_en),
        .wr_addr   (wb_addr),
        .wr_data   (wb_data)
    );

    // ------------------------------------------------------------------
    // Effective (post-writeback) flags and scoreboard
    // ------------------------------------------------------------------
    logic [FLAGS_W-1:0]  flags_eff;
    logic [NUM_REGS-1:0] wb_clear;
    logic [NUM_REGS-1:0] busy_eff;
    logic                flag_busy_eff;

    // NOTE: every signal assigned in always_comb gets a default first so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        wb_clear = '0;
        if (wb_en) wb_clear[wb_addr] = 1'b1;
    end

    assign flags_eff     = wb_flags_en ? wb_flags : flags_q;
    assign busy_eff      = busy_q & ~wb_clear;
    assign flag_busy_eff = flag_busy_q && !wb_flags_en;
    assign flags_out     = flags_eff;

    // ------------------------------------------------------------------
    // Hazard detection and upstream handshake
    // ------------------------------------------------------------------
    logic use_imm;
    logic needs_flags;
    logic haz_src1;
    logic haz_src2;
    logic haz_dest;
    logic haz_flags;
    logic hazard;
    logic accept;
    logic cond_ok;
    logic issue;

    assign use_imm = op_code_in[OP_IMM_BIT];

    // AL and NV are decided without reading NZCV, so only other conditions
    // (or a flag-setting op, to keep flag writes ordered) wait on flag_busy.
    assign needs_flags = s_bit_in ||
                         !((condition_in == COND_AL) || (condition_in == COND_NV));

    assign haz_src1  = busy_eff[src1_in];
    assign haz_src2  = !use_imm && busy_eff[src2_in];
    assign haz_dest  = busy_eff[destination_in];
    assign haz_flags = flag_busy_eff && needs_flags;
    assign hazard    = haz_src1 || haz_src2 || haz_dest || haz_flags;

    // in_ready is independent of in_valid to keep the handshake loop-free.
    assign in_ready = !hazard && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign cond_ok  = cond_pass(condition_in, flags_eff);
    assign issue    = accept && cond_ok;   // a failing condition is squashed

    // ------------------------------------------------------------------
    // Scoreboard next state: a same-cycle set beats a same-cycle clear
    // ------------------------------------------------------------------
    logic [NUM_REGS-1:0] busy_set;
    logic [NUM_REGS-1:0] busy_next;
    logic                flag_busy_next;

    always_comb begin
        busy_set = '0;
        if (issue) busy_set[destination_in] = 1'b1;
    end

    assign busy_next      = busy_eff | busy_set;
    assign flag_busy_next = flag_busy_eff || (issue && s_bit_in);

    // ------------------------------------------------------------------
    // Operand selection
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] operand_b_sel;

    assign operand_b_sel = use_imm ? {{(DATA_W-IMM_W){1'b0}}, immediat_value_in}
                                   : rf_rd_b;

    // ------------------------------------------------------------------
    // Sequential state and output pipeline register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_q          <= '0;
            flag_busy_q     <= 1'b0;
            flags_q         <= '0;
            out_valid       <= 1'b0;
            op_code_out     <= '0;
            s_bit_out       <= 1'b0;
            destination_out <= '0;
            operand_a_out   <= '0;
            operand_b_out   <= '0;
        end else begin
            busy_q      <= busy_next;
            flag_busy_q <= flag_busy_next;
            if (wb_flags_en) flags_q <= wb_flags;

            if (issue) begin
                out_valid       <= 1'b1;
                op_code_out     <= op_code_in;
                s_bit_out       <= s_bit_in;
                destination_out <= destination_in;
                operand_a_out   <= rf_rd_a;
                operand_b_out   <= operand_b_sel;
            end else if (out_ready) begin
                // Bundle taken (or none held) and nothing new to present.
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_operand_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_operand_fetch_stage
//   Directed, table-driven bench for operand_fetch_stage plus hand-written
//   multi-cycle sequences (RAW stall, immediate with busy src2, WAW, flag
//   hazard, backpressure, reset mid-stall). Inputs change 1 ns after the
//   rising edge; outputs are sampled there too, away from the edge.
// -----------------------------------------------------------------------------
module tb_operand_fetch_stage;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  op_code_in;
    logic [3:0]  condition_in;
    logic        s_bit_in;
    logic [3:0]  destination_in;
    logic [3:0]  src1_in;
    logic [3:0]  src2_in;
    logic [15:0] immediat_value_in;
    logic        wb_en;
    logic [3:0]  wb_addr;
    logic [31:0] wb_data;
    logic        wb_flags_en;
    logic [3:0]  wb_flags;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  op_code_out;
    logic        s_bit_out;
    logic [3:0]  destination_out;
    logic [31:0] operand_a_out;
    logic [31:0] operand_b_out;
    logic [3:0]  flags_out;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    operand_fetch_stage dut (
        .clk               (clk),
        .reset             (reset),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .op_code_in        (op_code_in),
        .condition_in      (condition_in),
        .s_bit_in          (s_bit_in),
        .destination_in    (destination_in),
        .src1_in           (src1_in),
        .src2_in           (src2_in),
        .immediat_value_in (immediat_value_in),
        .wb_en             (wb_en),
        .wb_addr           (wb_addr),
        .wb_data           (wb_data),
        .wb_flags_en       (wb_flags_en),
        .wb_flags          (wb_flags),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .op_code_out       (op_code_out),
        .s_bit_out         (s_bit_out),
        .destination_out   (destination_out),
        .operand_a_out     (operand_a_out),
        .operand_b_out     (operand_b_out),
        .flags_out         (flags_out)
    );

    typedef struct {
        logic [3:0]  op;
        logic [3:0]  cond;
        logic [3:0]  dest;
        logic [3:0]  src1;
        logic [3:0]  src2;
        logic [15:0] imm;
        logic        exp_valid;
        logic [31:0] exp_a;
        logic [31:0] exp_b;
        logic [31:0] wb_val;   // value execute writes back to dest afterwards
    } vec_t;

    localparam int NVEC = 12;
    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] op, input logic [3:0] cond,
                         input logic s, input logic [3:0] dest,
                         input logic [3:0] s1, input logic [3:0] s2,
                         input logic [15:0] imm);
        op_code_in        = op;
        condition_in      = cond;
        s_bit_in          = s;
        destination_in    = dest;
        src1_in           = s1;
        src2_in           = s2;
        immediat_value_in = imm;
    endtask

    task automatic do_wb(input logic [3:0] a, input logic [31:0] d);
        wb_en   = 1'b1;
        wb_addr = a;
        wb_data = d;
        tick();
        wb_en   = 1'b0;
    endtask

    function automatic vec_t mk(input logic [3:0] op, input logic [3:0] cond,
                                input logic [3:0] dest, input logic [3:0] s1,
                                input logic [3:0] s2, input logic [15:0] imm,
                                input logic ev, input logic [31:0] ea,
                                input logic [31:0] eb, input logic [31:0] wv);
        vec_t v;
        v.op = op; v.cond = cond; v.dest = dest; v.src1 = s1; v.src2 = s2;
        v.imm = imm; v.exp_valid = ev; v.exp_a = ea; v.exp_b = eb; v.wb_val = wv;
        return v;
    endfunction

    // Hang guard: the stimulus is fixed-length, so this only fires on a bench bug.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Register state entering the table: r1=0x11, r2=0x22, flags Z=1.
        // Each passing vector is followed by a writeback of its destination.
        vecs[0]  = mk(4'h1, COND_AL, 4'd3,  4'd1,  4'd2, 16'h0000, 1'b1, 32'h11, 32'h22,       32'h33);
        vecs[1]  = mk(4'h9, COND_AL, 4'd4,  4'd3,  4'd2, 16'hBEEF, 1'b1, 32'h33, 32'h0000BEEF, 32'h44);
        vecs[2]  = mk(4'h2, COND_EQ, 4'd5,  4'd4,  4'd1, 16'h0000, 1'b1, 32'h44, 32'h11,       32'h5A);
        vecs[3]  = mk(4'h2, COND_NE, 4'd6,  4'd5,  4'd3, 16'h0000, 1'b0, 32'h0,  32'h0,        32'h0);
        vecs[4]  = mk(4'h0, COND_NV, 4'd6,  4'd5,  4'd3, 16'h0000, 1'b0, 32'h0,  32'h0,        32'h0);
        vecs[5]  = mk(4'h3, COND_AL, 4'd6,  4'd6,  4'd5, 16'h0000, 1'b1, 32'h0,  32'h5A,       32'h66);
        vecs[6]  = mk(4'h4, COND_CS, 4'd7,  4'd1,  4'd1, 16'h0000, 1'b0, 32'h0,  32'h0,        32'h0);
        vecs[7]  = mk(4'h4, COND_CC, 4'd7,  4'd15, 4'd1, 16'h0000, 1'b1, 32'h0,  32'h11,       32'h77);
        vecs[8]  = mk(4'hF, COND_LS, 4'd8,  4'd7,  4'd0, 16'h0001, 1'b1, 32'h77, 32'h1,        32'h88);
        vecs[9]  = mk(4'h5, COND_GT, 4'd9,  4'd1,  4'd1, 16'h0000, 1'b0, 32'h0,  32'h0,        32'h0);
        vecs[10] = mk(4'h5, COND_LE, 4'd9,  4'd8,  4'd6, 16'h0000, 1'b1, 32'h88, 32'h66,       32'h99);
        vecs[11] = mk(4'h6, COND_GE, 4'd10, 4'd9,  4'd7, 16'h0000, 1'b1, 32'h99, 32'h77,       32'hA0);

        // ---------------- reset ----------------
        reset       = 1'b1;
        in_valid    = 1'b0;
        out_ready   = 1'b1;
        wb_en       = 1'b0;
        wb_addr     = '0;
        wb_data     = '0;
        wb_flags_en = 1'b0;
        wb_flags    = '0;
        drive(4'h0, COND_AL, 1'b0, 4'd0, 4'd0, 4'd0, 16'h0);
        tick();
        tick();
        check("rst_out_valid", out_valid, 0);
        check("rst_operand_a", operand_a_out, 0);
        check("rst_operand_b", operand_b_out, 0);
        check("rst_flags", flags_out, 0);
        check("rst_in_ready", in_ready, 1);
        reset = 1'b0;

        do_wb(4'd1, 32'h11);
        do_wb(4'd2, 32'h22);
        wb_flags_en = 1'b1;
        wb_flags    = 4'b0100;      // Z=1
        tick();
        wb_flags_en = 1'b0;
        check("flags_z_set", flags_out, 4'b0100);

        // ---------------- table-driven single issues ----------------
        for (int i = 0; i < NVEC; i++) begin
            drive(vecs[i].op, vecs[i].cond, 1'b0, vecs[i].dest,
                  vecs[i].src1, vecs[i].src2, vecs[i].imm);
            in_valid  = 1'b1;
            out_ready = 1'b1;
            #1;
            check($sformatf("v%0d_in_ready", i), in_ready, 1);
            tick();
            in_valid = 1'b0;
            check($sformatf("v%0d_out_valid", i), out_valid, vecs[i].exp_valid);
            if (vecs[i].exp_valid) begin
                check($sformatf("v%0d_operand_a", i), operand_a_out, vecs[i].exp_a);
                check($sformatf("v%0d_operand_b", i), operand_b_out, vecs[i].exp_b);
                check($sformatf("v%0d_op_code", i), op_code_out, vecs[i].op);
                check($sformatf("v%0d_dest", i), destination_out, vecs[i].dest);
                do_wb(vecs[i].dest, vecs[i].wb_val);
            end
        end

        // ---------------- RAW stall with forwarding ----------------
        drive(4'h1, COND_AL, 1'b0, 4'd3, 4'd1, 4'd2, 16'h0);
        in_valid = 1'b1;
        #1;
        check("raw_first_ready", in_ready, 1);
        tick();
        drive(4'h1, COND_AL, 1'b0, 4'd11, 4'd3, 4'd1, 16'h0);
        check("raw_first_valid", out_valid, 1);
        #1;
        check("raw_stall_0", in_ready, 0);
        tick();
        check("raw_stall_1", in_ready, 0);
        check("raw_bundle_drained", out_valid, 0);
        tick();
        check("raw_stall_2", in_ready, 0);
        wb_en   = 1'b1;
        wb_addr = 4'd3;
        wb_data = 32'h55;
        #1;
        check("raw_wb_cycle_ready", in_ready, 1);
        tick();
        wb_en    = 1'b0;
        in_valid = 1'b0;
        check("raw_out_valid", out_valid, 1);
        check("raw_forward_a", operand_a_out, 32'h55);
        check("raw_operand_b", operand_b_out, 32'h11);
        check("raw_dest", destination_out, 4'd11);

        // ---------------- immediate ignores a busy src2 (r11) ----------------
        drive(4'h9, COND_AL, 1'b0, 4'd12, 4'd1, 4'd11, 16'hBEEF);
        in_valid = 1'b1;
        #1;
        check("imm_busy_src2_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        check("imm_out_valid", out_valid, 1);
        check("imm_operand_b", operand_b_out, 32'h0000BEEF);
        check("imm_operand_a", operand_a_out, 32'h11);

        // ---------------- WAW on r11, cleared by same-cycle writeback ----------------
        drive(4'h1, COND_AL, 1'b0, 4'd11, 4'd1, 4'd2, 16'h0);
        #1;
        check("waw_stall", in_ready, 0);
        wb_en   = 1'b1;
        wb_addr = 4'd11;
        wb_data = 32'hBB;
        #1;
        check("waw_clear_same_cycle", in_ready, 1);
        tick();
        wb_en = 1'b0;
        do_wb(4'd12, 32'hCC);

        // ---------------- flag hazard ----------------
        drive(4'h1, COND_AL, 1'b1, 4'd13, 4'd1, 4'd2, 16'h0);
        in_valid = 1'b1;
        #1;
        check("flag_setter_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        check("flag_setter_s_bit", s_bit_out, 1);
        drive(4'h1, COND_AL, 1'b0, 4'd14, 4'd1, 4'd2, 16'h0);
        #1;
        check("flag_al_not_stalled", in_ready, 1);
        drive(4'h1, COND_GT, 1'b0, 4'd14, 4'd1, 4'd2, 16'h0);
        in_valid = 1'b1;
        #1;
        check("flag_gt_stall_0", in_ready, 0);
        tick();
        check("flag_gt_stall_1", in_ready, 0);
        wb_flags_en = 1'b1;
        wb_flags    = 4'b0000;      // Z=0, N==V: GT now passes
        wb_en       = 1'b1;
        wb_addr     = 4'd13;
        wb_data     = 32'h13;
        #1;
        check("flag_wb_cycle_ready", in_ready, 1);
        check("flag_forwarded", flags_out, 4'b0000);
        tick();
        wb_flags_en = 1'b0;
        wb_en       = 1'b0;
        in_valid    = 1'b0;
        check("flag_gt_issued", out_valid, 1);
        check("flag_gt_dest", destination_out, 4'd14);
        do_wb(4'd14, 32'hEE);

        // ---------------- backpressure ----------------
        drive(4'h2, COND_AL, 1'b0, 4'd1, 4'd2, 4'd2, 16'h0);
        in_valid  = 1'b1;
        out_ready = 1'b0;
        #1;
        check("bp_first_ready", in_ready, 1);
        tick();
        drive(4'h3, COND_AL, 1'b0, 4'd15, 4'd0, 4'd0, 16'h0);
        for (int k = 0; k < 3; k++) begin
            #1;
            check($sformatf("bp_hold%0d_ready", k), in_ready, 0);
            check($sformatf("bp_hold%0d_valid", k), out_valid, 1);
            check($sformatf("bp_hold%0d_a", k), operand_a_out, 32'h22);
            check($sformatf("bp_hold%0d_op", k), op_code_out, 4'h2);
            check($sformatf("bp_hold%0d_dest", k), destination_out, 4'd1);
            tick();
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        check("bp_b2b_valid", out_valid, 1);
        check("bp_b2b_op", op_code_out, 4'h3);
        check("bp_b2b_dest", destination_out, 4'd15);
        tick();
        check("bp_drained", out_valid, 0);
        do_wb(4'd1, 32'h11);
        do_wb(4'd15, 32'hFF);

        // ---------------- reset mid-stall ----------------
        drive(4'h1, COND_AL, 1'b0, 4'd5, 4'd1, 4'd2, 16'h0);
        in_valid  = 1'b1;
        out_ready = 1'b0;
        tick();
        drive(4'h1, COND_AL, 1'b0, 4'd6, 4'd5, 4'd2, 16'h0);
        #1;
        check("rs_stalled", in_ready, 0);
        check("rs_held_valid", out_valid, 1);
        in_valid = 1'b0;
        reset    = 1'b1;
        #1;
        check("rs_out_valid", out_valid, 0);
        check("rs_operand_a", operand_a_out, 0);
        check("rs_dest", destination_out, 0);
        check("rs_busy_cleared", in_ready, 1);
        tick();
        reset     = 1'b0;
        out_ready = 1'b1;
        check("rs_flags", flags_out, 0);
        drive(4'h1, COND_AL, 1'b0, 4'd3, 4'd1, 4'd2, 16'h0);
        in_valid = 1'b1;
        #1;
        check("rs_issue_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        check("rs_issue_valid", out_valid, 1);
        check("rs_reg_a_zero", operand_a_out, 0);
        check("rs_reg_b_zero", operand_b_out, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/operand_fetch_stage.md
Name: operand_fetch_stage

Overview:
- Pipeline stage directly downstream of the instruction fetch/decode register.
- Consumes the decoded fields: condition, s-bit, op-code, destination, src1, src2, immediate.
- Owns the 16x32 architectural register file, the NZCV flag register and a busy scoreboard.
- Evaluates the condition field, stalls upstream on RAW/WAW/flag hazards, and presents operands to the execute stage through a valid/ready pipeline register.

Parameters:
- DATA_W, 32, register and operand width.
- NUM_REGS, 16, architectural registers; address width is log2(NUM_REGS) = 4.
- IMM_W, 16, immediate field width; zero-extended to DATA_W.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high; clears all state.
- in_valid  in  1  decoded instruction present.
- in_ready  out  1  stage accepts the instruction this cycle.
- op_code_in  in  4  op-code; op_code_in[3]=1 selects immediate as operand B.
- condition_in  in  4  condition code.
- s_bit_in  in  1  instruction updates flags.
- destination_in  in  4  destination register.
- src1_in  in  4  operand A register.
- src2_in  in  4  operand B register (ignored when immediate).
- immediat_value_in  in  16  immediate.
- wb_en  in  1  register writeback strobe from execute/writeback.
- wb_addr  in  4  writeback register.
- wb_data  in  32  writeback data.
- wb_flags_en  in  1  flag writeback strobe.
- wb_flags  in  4  {N,Z,C,V}.
- out_valid  out  1  operand bundle valid.
- out_ready  in  1  execute stage accepts the bundle.
- op_code_out  out  4  registered op-code.
- s_bit_out  out  1  registered s-bit.
- destination_out  out  4  registered destination.
- operand_a_out  out  32  value of src1.
- operand_b_out  out  32  value of src2, or zero-extended immediate.
- flags_out  out  4  current NZCV, including same-cycle writeback.

Behaviour:
- **Reset** (async): register file, flags, busy[15:0], flag_busy and out_valid all go to 0; every output goes to 0. Reset mid-stall drops the held and in-flight instruction; no writes survive.
- **Writeback forwarding.** A write on wb_en/wb_flags_en in cycle N is visible to that same cycle's operand read, condition evaluation and hazard check. The register file and flag register are write-first.
- **Busy clearing.** Writeback clears busy[wb_addr]; wb_flags_en clears flag_busy. A write to a non-busy register still updates it.
- **Hazard**, evaluated against effective busy (after same-cycle clears):
  - busy[src1];
  - or (!op_code_in[3] && busy[src2]);
  - or busy[destination_in] (WAW);
  - or flag_busy && (s_bit_in || condition_in not in {AL, NV}).
- **Handshake.** in_ready = !hazard && (!out_valid || out_ready). Accept = in_valid && in_ready. in_ready may depend combinationally on in_valid's fields but never on in_valid itself.
- **Condition codes** (cpu_pkg constants):
  - 0 AL, 1 EQ Z, 2 NE !Z, 3 CS C, 4 CC !C, 5 MI N, 6 PL !N, 7 VS V, 8 VC !V;
  - 9 HI C&!Z, 10 LS !C|Z, 11 GE N==V, 12 LT N!=V, 13 GT !Z&(N==V), 14 LE Z|(N!=V), 15 NV never.
- **Accept with condition pass** (next edge):
  - out_valid=1 and the bundle is registered;
  - busy[destination_in]=1;
  - flag_busy=1 if s_bit_in.
  - If the same register is set and cleared in one cycle, set wins.
- **Accept with condition fail:** the instruction is consumed and squashed. No bundle is produced, busy is unchanged, and out_valid goes to 0 if the held bundle was taken.
- **Output handling.**
  - out_valid && !out_ready: the bundle holds stable.
  - Bundle taken with no new accept: out_valid goes to 0.
- **Latency:** 1 cycle from accept to out_valid, with no hazard and no backpressure. Throughput is 1 per cycle.
- **Execute contract:** it issues exactly one wb_en per passed instruction, plus one wb_flags_en if s_bit was set.

Decomposition:
- **cpu_pkg:** COND_* constants, OP_IMM_BIT=3, field widths, NZCV bit indices.
- **Sub-module `regfile`:** NUM_REGS x DATA_W, two async read ports, one write port, write-first bypass, async reset.
- **Inline logic:** condition evaluation and the scoreboard stay in operand_fetch_stage.

Test Plan:
- **Basic issue.** After reset, wb r1=0x11, r2=0x22. Then issue op 0x1, AL, src1=1, src2=2, dest=3. Required: out_valid next cycle with A=0x11, B=0x22, busy[3]=1.
- **Immediate.** Issue op 0x9 with imm 0xBEEF. Required: B=0x0000BEEF; src2 is ignored even while busy.
- **RAW stall.** Issue dest=3, then immediately src1=3. Required: in_ready=0 until wb r3=0x55. In the wb cycle in_ready=1 and A=0x55 (forwarded).
- **Conditions.** With flags Z=1: EQ issues, NE is squashed (no out_valid, busy unchanged), NV is always squashed. Then set flag_busy with an s_bit instruction; a following GT stalls until wb_flags.
- **Backpressure.** Hold out_ready=0 for 3 cycles with out_valid=1. Required: bundle stable, in_ready=0. Release: the next instruction issues back-to-back.
- **Reset mid-stall.** Assert reset while stalled. Required: out_valid=0, all busy cleared, register read returns 0.
